// File: rtl/fp_acc_pkg.sv
// Shared types and constants for the accumulator normalize/round path.
// Optional build macro: FP_ACC_SUBNORMAL_EN (gradual underflow in fp_acc_normalize).
package fp_acc_pkg;

  localparam int FP32_BIAS = 127;
  localparam int EXP_MAX   = 255;
  localparam int FRAC_BITS = 23;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
    logic zero;
  } fp_acc_flags_t;

  typedef struct packed {
    logic                 sign;
    logic [7:0]           exp;
    logic [FRAC_BITS-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_acc_round_rne.sv
// Round-to-nearest-even on a normalized significand (hidden bit at MSB).
// Pure combinational; reused by later accumulator stages.
module fp_acc_round_rne
  import fp_acc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0]         sig,
  input  logic                 sticky_in,
  output logic [FRAC_BITS-1:0] frac,
  output logic                 guard,
  output logic                 sticky,
  output logic                 carry
);

  logic [FRAC_BITS-1:0] frac_raw;
  logic                 inc;

  assign frac_raw = sig[W-2 -: FRAC_BITS];
  assign guard    = sig[W-2-FRAC_BITS];
  assign sticky   = sticky_in | (|sig[W-3-FRAC_BITS:0]);
  assign inc      = guard & (sticky | frac_raw[0]);

  // An all-ones fraction wraps to zero and reports the carry.
  assign {carry, frac} = {1'b0, frac_raw}
                       + {{FRAC_BITS{1'b0}}, inc};

endmodule

// File: rtl/fp_acc_normalize.sv
// Tree sum -> binary32: abs/sign, normalize with LZA fix, round/pack.
// Build macro FP_ACC_SUBNORMAL_EN enables subnormal results (else flush).
module fp_acc_normalize
  import fp_acc_pkg::*;
#(
  parameter int SUM_W  = 32,
  parameter int FRAC_W = 24,
  parameter int LZC_W  = $clog2(SUM_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum_in,
  input  logic [LZC_W-1:0] lzc_in,
  input  logic [7:0]       exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res_out,
  output logic [3:0]       flags_out
);

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  // ---- stage 1: abs / sign ----
  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic [SUM_W-1:0]  s1_mag;
  logic [LZC_W-1:0]  s1_lzc;
  logic signed [9:0] s1_e;
  logic [SUM_W-1:0]  mag_in;

  // Negation of the most negative value wraps to 2^(SUM_W-1), as wanted.
  assign mag_in = sum_in[SUM_W-1] ? -sum_in : sum_in;

  // Capture magnitude, sign and the exponent of the sum's MSB position.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
      s1_lzc   <= '0;
      s1_e     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= sum_in[SUM_W-1];
      s1_zero  <= (sum_in == '0);
      s1_mag   <= mag_in;
      s1_lzc   <= lzc_in;
      s1_e     <= {2'b00, exp_in}
                + 10'(SUM_W - 1 - FRAC_W);
    end
  end

  // ---- stage 2: normalize ----
  logic [SUM_W-1:0]  sh0;
  logic [SUM_W-1:0]  sh_n;
  logic              corr;
  logic signed [9:0] e_n;
  logic              lzc_ok;

  assign sh0  = s1_mag << s1_lzc;
  assign corr = ~sh0[SUM_W-1];
  assign sh_n = corr ? (sh0 << 1) : sh0;
  assign e_n  = s1_e - 10'(s1_lzc) - {9'b0, corr};

  // LZA may undercount by one but must never overshoot.
  assign lzc_ok = (((s1_mag << s1_lzc) >> s1_lzc) == s1_mag)
               && sh_n[SUM_W-1];

  a_lzc_legal: assert property (
    @(posedge clk) disable iff (rst)
    (s1_valid && !s1_zero) |-> lzc_ok
  );

  logic              s2_valid;
  logic              s2_sign;
  logic              s2_zero;
  logic [SUM_W-1:0]  s2_sh;
  logic signed [9:0] s2_e;

  // Register the normalized significand and its exponent.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_sh    <= '0;
      s2_e     <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_sh    <= sh_n;
      s2_e     <= e_n;
    end
  end

  // ---- stage 3: round / pack ----
  logic                 tiny;
  logic [SUM_W-1:0]     rnd_sig;
  logic                 rnd_stk;
  logic [FRAC_BITS-1:0] frac_r;
  logic                 guard;
  logic                 sticky;
  logic                 carry;
  logic signed [9:0]    e_r;
  fp32_t                res_n;
  fp_acc_flags_t        flg_n;

  assign tiny = (s2_e <= 10'sd0);

`ifdef FP_ACC_SUBNORMAL_EN
  logic signed [9:0] sub_amt;

  assign sub_amt = 10'sd1 - s2_e;

  // Denormalize tiny values; bits pushed out feed the sticky bit.
  always_comb begin
    rnd_sig = s2_sh;
    rnd_stk = 1'b0;
    if (tiny) begin
      rnd_sig = s2_sh >> sub_amt;
      rnd_stk = |(s2_sh & ~({SUM_W{1'b1}} << sub_amt));
    end
  end
`else
  assign rnd_sig = s2_sh;
  assign rnd_stk = 1'b0;
`endif

  fp_acc_round_rne #(
    .W (SUM_W)
  ) u_round (
    .sig       (rnd_sig),
    .sticky_in (rnd_stk),
    .frac      (frac_r),
    .guard     (guard),
    .sticky    (sticky),
    .carry     (carry)
  );

  assign e_r = carry ? (s2_e + 10'sd1) : s2_e;

  // Select packed result and flags by special case priority.
  always_comb begin
    res_n         = '{sign: s2_sign, exp: e_r[7:0], frac: frac_r};
    flg_n         = '0;
    flg_n.inexact = guard | sticky;
    if (s2_zero) begin
      res_n      = '0;
      flg_n      = '0;
      flg_n.zero = 1'b1;
    end else if (tiny) begin
`ifdef FP_ACC_SUBNORMAL_EN
      if (sub_amt >= 10'sd25) begin
        res_n           = '{sign: s2_sign, exp: 8'd0, frac: '0};
        flg_n.underflow = 1'b1;
        flg_n.inexact   = 1'b1;
      end else begin
        res_n           = '{sign: s2_sign,
                            exp:  {7'd0, carry},
                            frac: frac_r};
        flg_n.underflow = guard | sticky;
      end
`else
      res_n           = '{sign: s2_sign, exp: 8'd0, frac: '0};
      flg_n.underflow = 1'b1;
      flg_n.inexact   = 1'b1;
`endif
    end else if (e_r >= 10'(EXP_MAX)) begin
      res_n          = '{sign: s2_sign, exp: 8'hFF, frac: '0};
      flg_n.overflow = 1'b1;
      flg_n.inexact  = 1'b1;
    end
  end

  // Output register holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_out   <= '0;
      flags_out <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        res_out   <= res_n;
        flags_out <= flg_n;
      end
    end
  end

endmodule

// File: tb/tb_fp_acc_normalize.sv
// Directed bench for fp_acc_normalize: vector table, backpressure, reset.
// Expected values are hand-computed binary32 encodings.
module tb_fp_acc_normalize;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] sum_in;
  logic [4:0]  lzc_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res_out;
  logic [3:0]  flags_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_acc_normalize dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .lzc_in    (lzc_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out),
    .flags_out (flags_out)
  );

  typedef struct {
    logic [31:0] sum;
    logic [4:0]  lzc;
    logic [7:0]  exp;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    sum_in    = v.sum;
    lzc_in    = v.lzc;
    exp_in    = v.exp;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency[%0d]", idx), 32'(lat), 32'd3);
    chk($sformatf("res[%0d]", idx), res_out, v.res);
    chk($sformatf("flags[%0d]", idx), 32'(flags_out), 32'(v.flags));
  endtask

  logic        pat [4];
  int          sent;
  int          rcv;
  int          cyc;
  logic        acc;
  logic        take;
  logic        stalled_prev;
  logic [31:0] held_res;

  initial begin
    vecs[0]  = '{32'h01000000, 5'd7, 8'd127, 32'h3F800000, 4'b0000};
    vecs[1]  = '{32'h01000000, 5'd6, 8'd127, 32'h3F800000, 4'b0000};
    vecs[2]  = '{32'hFE800000, 5'd7, 8'd127, 32'hBFC00000, 4'b0000};
    vecs[3]  = '{32'h400000C0, 5'd1, 8'd121, 32'h3F800002, 4'b0010};
    vecs[4]  = '{32'h00000000, 5'd3, 8'd77,  32'h00000000, 4'b0001};
    vecs[5]  = '{32'h40000000, 5'd1, 8'd255, 32'h7F800000, 4'b1010};
`ifdef FP_ACC_SUBNORMAL_EN
    vecs[6]  = '{32'h01000000, 5'd7, 8'd0,   32'h00400000, 4'b0000};
`else
    vecs[6]  = '{32'h01000000, 5'd7, 8'd0,   32'h00000000, 4'b0110};
`endif
    vecs[7]  = '{32'h80000000, 5'd0, 8'd127, 32'hC3000000, 4'b0000};
    vecs[8]  = '{32'h01FFFFFF, 5'd7, 8'd127, 32'h40000000, 4'b0010};
    vecs[9]  = '{32'h01000001, 5'd7, 8'd127, 32'h3F800000, 4'b0010};
    vecs[10] = '{32'h01000000, 5'd7, 8'd1,   32'h00800000, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sum_in    = '0;
    lzc_in    = '0;
    exp_in    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", res_out, 32'd0);
    chk("rst_flags", 32'(flags_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: ready pattern 1-0-0-1, ten back-to-back items.
    pat[0] = 1'b1;
    pat[1] = 1'b0;
    pat[2] = 1'b0;
    pat[3] = 1'b1;
    sent = 0;
    rcv = 0;
    cyc = 0;
    stalled_prev = 1'b0;
    held_res = '0;
    while (rcv < 10 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 10);
      sum_in    = 32'h01000000;
      lzc_in    = 5'd7;
      exp_in    = 8'(100 + sent);
      #1;
      if (stalled_prev) begin
        chk("bp_hold_valid", 32'(out_valid), 32'd1);
        chk("bp_hold_res", res_out, held_res);
      end
      chk("bp_in_ready", 32'(in_ready),
          32'(!(out_valid && !out_ready)));
      acc  = in_valid && in_ready;
      take = out_valid && out_ready;
      if (take) begin
        chk($sformatf("bp_res[%0d]", rcv), res_out,
            {1'b0, 8'(100 + rcv), 23'd0});
        rcv++;
      end
      stalled_prev = out_valid && !out_ready;
      held_res = res_out;
      @(posedge clk);
      if (acc) sent++;
      cyc++;
    end
    chk("bp_count", 32'(rcv), 32'd10);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_no_dup", 32'(out_valid), 32'd0);
    end

    // Reset with items in flight discards them all.
    @(negedge clk);
    in_valid = 1'b1;
    sum_in   = 32'h01000000;
    lzc_in   = 5'd7;
    exp_in   = 8'd127;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_flush", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
